// File: rtl/mppc_pkg.sv
// Shared definitions for the MPPC counter readout: FSM encoding, protocol constants, field positions.
// Latency: none (declarations only); backpressure: none. Optional SUM state under SPI_COUNT_CHECKSUM_EN.
package mppc_pkg;

   localparam int          NCH_MAX     = 16;
   localparam int          BYTE_W      = 8;
   localparam logic [7:0]  HDR_DEFAULT = 8'hA5;
   localparam int          CMD_CLR_BIT = 7;
   localparam int          CMD_SEL_MSB = 3;
   localparam int          SEL_W       = CMD_SEL_MSB + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_DATA
`ifdef SPI_COUNT_CHECKSUM_EN
      , ST_SUM
`endif
   } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus a third stage for rise/fall detection.
// Latency: edge flags are high in the 3rd CLK cycle after the pin edge; backpressure: none.
module sync_edge (
   input  logic CLK,
   input  logic RST_N,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [2:0] sr;

   // Resetting low means a chip select already low at reset release shows no fall,
   // so a frame in progress is ignored until a fresh one starts.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) sr <= '0;
      else        sr <= {sr[1:0], d};
   end

   assign q    = sr[1];
   assign rise = sr[1] & ~sr[2];
   assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_count_responder.sv
// SPI mode-0 responder: command byte selects a counter, snapshot byte is shifted back (checksum byte with SPI_COUNT_CHECKSUM_EN).
// Latency: 3 CLK from pin edge to internal event, MISO 4 CLK after SCK fall; backpressure: none, host paces the frame.
module spi_count_responder
   import mppc_pkg::*;
#(
   parameter int         NCH = NCH_MAX,
   parameter int         CW  = BYTE_W,
   parameter logic [7:0] HDR = HDR_DEFAULT
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              SCK,
   input  logic              SS_N,
   input  logic              MOSI,
   output logic              MISO,
   output logic              MISO_OE,
   input  logic [NCH*CW-1:0] COUNTS,
   output logic [NCH-1:0]    CLR_STB,
   output logic              RD_STB
);

   logic sck_rise, sck_fall, sck_lvl_unused;
   logic ss_lvl, ss_fall, ss_rise_unused;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;

   sync_edge u_sck  (.CLK(CLK), .RST_N(RST_N), .d(SCK),  .q(sck_lvl_unused), .rise(sck_rise),         .fall(sck_fall));
   sync_edge u_ss   (.CLK(CLK), .RST_N(RST_N), .d(SS_N), .q(ss_lvl),         .rise(ss_rise_unused),   .fall(ss_fall));
   sync_edge u_mosi (.CLK(CLK), .RST_N(RST_N), .d(MOSI), .q(mosi_s),         .rise(mosi_rise_unused), .fall(mosi_fall_unused));

   state_t             state_q, state_d;
   logic [2:0]         bit_q, bit_d;
   logic [BYTE_W-1:0]  shift_q, shift_d;
   logic [BYTE_W-2:0]  rx_q, rx_d;
   logic               clr_q, clr_d;
   logic [SEL_W-1:0]   sel_q, sel_d, sel_now;
   logic [CW-1:0]      snap_now;
   logic               oe_q, rd_q, rd_d, frame_done;
   logic [NCH-1:0]     clr_stb_q, clr_stb_d;
`ifdef SPI_COUNT_CHECKSUM_EN
   logic [BYTE_W-1:0]  cmd_q, cmd_d, snap_q, snap_d;
`endif

   always_comb begin
      state_d    = state_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      rx_d       = rx_q;
      clr_d      = clr_q;
      sel_d      = sel_q;
      rd_d       = 1'b0;
      clr_stb_d  = '0;
      frame_done = 1'b0;
`ifdef SPI_COUNT_CHECKSUM_EN
      cmd_d      = cmd_q;
      snap_d     = snap_q;
`endif
      sel_now  = {rx_q[CMD_SEL_MSB-1:0], mosi_s};
      // Out-of-range selects fall through and read as zero.
      snap_now = '0;
      for (int k = 0; k < NCH; k++)
         if (sel_now == SEL_W'(k)) snap_now = COUNTS[k*CW +: CW];

      unique case (state_q)
         ST_IDLE: begin
            if (ss_fall) begin
               state_d = ST_CMD;
               shift_d = HDR;
               bit_d   = '0;
            end
         end
         default: begin
            if (ss_lvl) begin
               state_d = ST_IDLE;
               shift_d = '0;
               bit_d   = '0;
            end else if (sck_rise) begin
               bit_d = bit_q + 3'd1;
               if (state_q == ST_CMD) begin
                  rx_d = {rx_q[BYTE_W-3:0], mosi_s};
                  if (bit_q == 3'd7) begin
                     clr_d   = rx_q[CMD_CLR_BIT-1];
                     sel_d   = sel_now;
                     shift_d = snap_now;
                     state_d = ST_DATA;
`ifdef SPI_COUNT_CHECKSUM_EN
                     cmd_d   = {rx_q, mosi_s};
                     snap_d  = snap_now;
`endif
                  end
               end else if (bit_q == 3'd7) begin
`ifdef SPI_COUNT_CHECKSUM_EN
                  if (state_q == ST_DATA) begin
                     state_d = ST_SUM;
                     shift_d = cmd_q ^ snap_q;
                  end else begin
                     frame_done = 1'b1;
                  end
`else
                  frame_done = 1'b1;
`endif
               end
            // The fall right after a byte boundary must keep the freshly loaded MSB on the line.
            end else if (sck_fall && bit_q != 3'd0) begin
               shift_d = {shift_q[BYTE_W-2:0], 1'b0};
            end
         end
      endcase

      if (frame_done) begin
         rd_d    = 1'b1;
         state_d = ST_CMD;
         shift_d = HDR;
         if (clr_q)
            for (int k = 0; k < NCH; k++)
               clr_stb_d[k] = (sel_q == SEL_W'(k));
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         bit_q     <= '0;
         shift_q   <= '0;
         rx_q      <= '0;
         clr_q     <= 1'b0;
         sel_q     <= '0;
         oe_q      <= 1'b0;
         rd_q      <= 1'b0;
         clr_stb_q <= '0;
`ifdef SPI_COUNT_CHECKSUM_EN
         cmd_q     <= '0;
         snap_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         rx_q      <= rx_d;
         clr_q     <= clr_d;
         sel_q     <= sel_d;
         oe_q      <= (state_d != ST_IDLE);
         rd_q      <= rd_d;
         clr_stb_q <= clr_stb_d;
`ifdef SPI_COUNT_CHECKSUM_EN
         cmd_q     <= cmd_d;
         snap_q    <= snap_d;
`endif
      end
   end

   assign MISO    = shift_q[BYTE_W-1];
   assign MISO_OE = oe_q;
   assign RD_STB  = rd_q;
   assign CLR_STB = clr_stb_q;

endmodule

// File: tb/tb_spi_count_responder.sv
// Directed bench for spi_count_responder: table of single-frame reads plus hand sequences for
// snapshot stability, abort, back-to-back frames and mid-frame reset (checksum byte with SPI_COUNT_CHECKSUM_EN).
module tb_spi_count_responder;

   localparam int HALF = 80;   // 8 CLK per SCK phase -> 600 kHz at 9.6 MHz

   logic          CLK = 1'b0;
   logic          RST_N, SCK, SS_N, MOSI;
   logic          MISO, MISO_OE, RD_STB;
   logic [127:0]  COUNTS;
   logic [15:0]   CLR_STB;

   spi_count_responder dut (
      .CLK(CLK), .RST_N(RST_N), .SCK(SCK), .SS_N(SS_N), .MOSI(MOSI),
      .MISO(MISO), .MISO_OE(MISO_OE), .COUNTS(COUNTS),
      .CLR_STB(CLR_STB), .RD_STB(RD_STB)
   );

   always #5 CLK = ~CLK;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else n_pass++;
   endtask

   // Strobe monitor, cleared by pulsing mon_rst
   logic        mon_rst = 1'b1;
   int          rd_cnt, rd_run, rd_maxrun, clr_cycles, clr_run, clr_maxrun, multi_hot;
   logic [15:0] clr_or;

   always @(negedge CLK) begin
      if (mon_rst) begin
         rd_cnt <= 0; rd_run <= 0; rd_maxrun <= 0;
         clr_cycles <= 0; clr_run <= 0; clr_maxrun <= 0; multi_hot <= 0; clr_or <= '0;
      end else begin
         if (RD_STB) begin
            rd_cnt <= rd_cnt + 1;
            rd_run <= rd_run + 1;
            if (rd_run + 1 > rd_maxrun) rd_maxrun <= rd_run + 1;
         end else rd_run <= 0;
         if (CLR_STB != '0) begin
            clr_cycles <= clr_cycles + 1;
            clr_run    <= clr_run + 1;
            clr_or     <= clr_or | CLR_STB;
            if (clr_run + 1 > clr_maxrun) clr_maxrun <= clr_run + 1;
            if ($countones(CLR_STB) > 1) multi_hot <= multi_hot + 1;
         end else clr_run <= 0;
      end
   end

   task automatic mon_clear();
      mon_rst = 1'b1;
      @(negedge CLK);
      #1 mon_rst = 1'b0;
   endtask

   task automatic set_base();
      for (int k = 0; k < 16; k++) COUNTS[k*8 +: 8] = 8'h10 + 8'(k);
   endtask

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         MOSI = tx[i];
         #(HALF);
         rx[i] = MISO;
         SCK = 1'b1;
         #(HALF);
         SCK = 1'b0;
      end
   endtask

   task automatic frame(input logic [7:0] cmd, output logic [7:0] hdr, output logic [7:0] dat,
                        output logic [7:0] sum);
      SS_N = 1'b0;
      #(HALF);
      xfer(cmd, hdr);
      xfer(8'h00, dat);
`ifdef SPI_COUNT_CHECKSUM_EN
      xfer(8'h00, sum);
`else
      sum = 8'h00;
`endif
      #(HALF);
      SS_N = 1'b1;
      #(2*HALF);
   endtask

   typedef struct {
      logic [7:0]  cmd;
      int          ch;
      logic [7:0]  val;
      logic [7:0]  exp_dat;
      logic [15:0] exp_clr;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [7:0] h, d, s, h1, d1, s1;
      vecs[0] = '{8'h03, 3,  8'h5C, 8'h5C, 16'h0000};
      vecs[1] = '{8'h85, 5,  8'hFF, 8'hFF, 16'h0020};
      vecs[2] = '{8'h0A, 10, 8'h3C, 8'h3C, 16'h0000};
      vecs[3] = '{8'hF0, 0,  8'h81, 8'h81, 16'h0001};  // bits 6:4 ignored, clear ch0
      vecs[4] = '{8'h8F, 15, 8'h7E, 8'h7E, 16'h8000};
      vecs[5] = '{8'h70, 0,  8'h42, 8'h42, 16'h0000};  // bits 6:4 ignored, no clear

      RST_N = 1'b0; SCK = 1'b0; SS_N = 1'b1; MOSI = 1'b0;
      set_base();
      #20;
      chk("reset_miso",    32'(MISO),    32'h0);
      chk("reset_oe",      32'(MISO_OE), 32'h0);
      chk("reset_clr_stb", 32'(CLR_STB), 32'h0);
      chk("reset_rd_stb",  32'(RD_STB),  32'h0);
      RST_N = 1'b1;
      #40;

      for (int v = 0; v < 6; v++) begin
         set_base();
         COUNTS[vecs[v].ch*8 +: 8] = vecs[v].val;
         mon_clear();
         frame(vecs[v].cmd, h, d, s);
         chk($sformatf("v%0d_hdr", v),      32'(h),          32'hA5);
         chk($sformatf("v%0d_data", v),     32'(d),          32'(vecs[v].exp_dat));
`ifdef SPI_COUNT_CHECKSUM_EN
         chk($sformatf("v%0d_sum", v),      32'(s),          32'(vecs[v].cmd ^ vecs[v].exp_dat));
`endif
         chk($sformatf("v%0d_rd_cnt", v),   32'(rd_cnt),     32'h1);
         chk($sformatf("v%0d_rd_width", v), 32'(rd_maxrun),  32'h1);
         chk($sformatf("v%0d_clr_mask", v), 32'(clr_or),     32'(vecs[v].exp_clr));
         chk($sformatf("v%0d_clr_width", v), 32'(clr_cycles), (vecs[v].exp_clr != 0) ? 32'h1 : 32'h0);
      end
      chk("clr_onehot", 32'(multi_hot), 32'h0);

      // Snapshot must hold while the live counter moves during DATA
      set_base();
      COUNTS[2*8 +: 8] = 8'h10;
      mon_clear();
      SS_N = 1'b0;
      #(HALF);
      xfer(8'h02, h);
      COUNTS[2*8 +: 8] = 8'h11;
      xfer(8'h00, d);
`ifdef SPI_COUNT_CHECKSUM_EN
      xfer(8'h00, s);
      chk("snap_sum", 32'(s), 32'h12);
`endif
      #(HALF); SS_N = 1'b1; #(2*HALF);
      chk("snap_data", 32'(d), 32'h10);
      chk("snap_rd",   32'(rd_cnt), 32'h1);

      // Abort after 4 data bits of a clear-on-read command
      set_base();
      COUNTS[1*8 +: 8] = 8'h99;
      mon_clear();
      SS_N = 1'b0;
      #(HALF);
      xfer(8'h81, h);
      for (int i = 0; i < 4; i++) begin
         #(HALF); SCK = 1'b1; #(HALF); SCK = 1'b0;
      end
      #(HALF);
      SS_N = 1'b1;
      #40;
      chk("abort_oe",   32'(MISO_OE), 32'h0);
      chk("abort_miso", 32'(MISO),    32'h0);
      #(4*HALF);
      chk("abort_rd",  32'(rd_cnt),     32'h0);
      chk("abort_clr", 32'(clr_cycles), 32'h0);
      mon_clear();
      frame(8'h01, h, d, s);
      chk("after_abort_hdr",  32'(h), 32'hA5);
      chk("after_abort_data", 32'(d), 32'h99);
      chk("after_abort_rd",   32'(rd_cnt), 32'h1);

      // Two frames under one chip select
      set_base();
      COUNTS[0*8 +: 8]  = 8'h01;
      COUNTS[15*8 +: 8] = 8'hEE;
      mon_clear();
      SS_N = 1'b0;
      #(HALF);
      xfer(8'h00, h);
      xfer(8'h00, d);
`ifdef SPI_COUNT_CHECKSUM_EN
      xfer(8'h00, s);
      chk("b2b_sum0", 32'(s), 32'h01);
`endif
      xfer(8'h0F, h1);
      xfer(8'h00, d1);
`ifdef SPI_COUNT_CHECKSUM_EN
      xfer(8'h00, s1);
      chk("b2b_sum1", 32'(s1), 32'hE1);
`endif
      #(HALF); SS_N = 1'b1; #(2*HALF);
      chk("b2b_hdr0",  32'(h),  32'hA5);
      chk("b2b_data0", 32'(d),  32'h01);
      chk("b2b_hdr1",  32'(h1), 32'hA5);
      chk("b2b_data1", 32'(d1), 32'hEE);
      chk("b2b_rd",    32'(rd_cnt), 32'h2);

      // Reset in the middle of DATA, released while the old frame continues
      set_base();
      COUNTS[3*8 +: 8] = 8'hC3;
      mon_clear();
      SS_N = 1'b0;
      #(HALF);
      xfer(8'h83, h);
      #(HALF);
      chk("midrst_pre_miso", 32'(MISO),    32'h1);
      chk("midrst_pre_oe",   32'(MISO_OE), 32'h1);
      RST_N = 1'b0;
      #1;
      chk("midrst_miso", 32'(MISO),    32'h0);
      chk("midrst_oe",   32'(MISO_OE), 32'h0);
      #19;
      RST_N = 1'b1;
      xfer(8'h00, d);
      chk("midrst_ignored_oe", 32'(MISO_OE), 32'h0);
      #(HALF); SS_N = 1'b1; #(2*HALF);
      chk("midrst_no_rd",  32'(rd_cnt),     32'h0);
      chk("midrst_no_clr", 32'(clr_cycles), 32'h0);
      mon_clear();
      frame(8'h03, h, d, s);
      chk("midrst_next_data", 32'(d), 32'hC3);
      chk("midrst_next_rd",   32'(rd_cnt), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
